// File: rtl/bram36k_pkg.sv
// Shared constants, FSM state type and byte-parity helper for the BRAM36K readback engine.
package bram36k_pkg;
    localparam int BRAM36K_DEPTH = 1024;
    localparam int BRAM36K_AW    = 10;
    localparam int BRAM36K_DW    = 32;
    localparam int BRAM36K_PW    = 4;
    localparam int BRAM36K_LW    = BRAM36K_AW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} bram36k_rd_state_t;

    // Even parity per byte: bit i is the XOR of data byte i.
    function automatic logic [BRAM36K_PW-1:0] bram36k_byte_par(input logic [BRAM36K_DW-1:0] d);
        logic [BRAM36K_PW-1:0] p;
        for (int i = 0; i < BRAM36K_PW; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction
endpackage

// File: rtl/bram36k_skid_fifo.sv
// Two-entry FIFO that owns the stream valid and payload registers; head entry drives the output.
module bram36k_skid_fifo
    import bram36k_pkg::*;
#(
    parameter int W = BRAM36K_DW + BRAM36K_PW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   count,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;

    // Pop is only ever requested with a valid head, and push never arrives into a full FIFO.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = push_data;
                else               tail_d = push_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = push_data;
                end else begin
                    head_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count     = cnt_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = head_q;
endmodule

// File: rtl/bram36k_reader.sv
// Sequential wrap-around readback of a TDP_RAM36K port into a valid/ready stream.
// Define BRAM36K_READER_PARITY_CHECK_EN to enable the sticky per-byte parity checker.
module bram36k_reader
    import bram36k_pkg::*;
#(
    parameter int ADDR_LSB = 5
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic [9:0]  BASE_ADDR,
    input  logic [10:0] LENGTH,
    output logic        BUSY,
    output logic        DONE,
    output logic        REN,
    output logic [14:0] ADDR,
    input  logic [31:0] RDATA,
    input  logic [3:0]  RPARITY,
    output logic [31:0] M_DATA,
    output logic [3:0]  M_PARITY,
    output logic        M_VALID,
    input  logic        M_READY,
    output logic        M_LAST,
    output logic        PARITY_ERR
);
    bram36k_rd_state_t       state_q, state_d;
    logic [BRAM36K_AW-1:0]   rd_addr_q, rd_addr_d;
    logic [BRAM36K_AW-1:0]   addr_out_q, addr_out_d;
    logic [BRAM36K_LW-1:0]   len_q, len_d;
    logic [BRAM36K_LW-1:0]   iss_cnt_q, iss_cnt_d;
    logic [BRAM36K_LW-1:0]   pop_cnt_q, pop_cnt_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    done_q, done_d;

    logic [1:0]              fifo_cnt;
    logic [1:0]              occ;
    logic                    pop;
    logic                    ren;
    logic [BRAM36K_AW-1:0]   word_addr;
    logic [BRAM36K_DW+BRAM36K_PW-1:0] fifo_dout;

    assign pop = M_VALID && M_READY;
    // Counting this cycle's pop lets a steady-state stream sustain one word per cycle.
    assign occ = 2'(rd_pend_q) + fifo_cnt - 2'(pop);
    assign ren = (state_q == READ) && (iss_cnt_q != len_q) && (occ < 2'd2);

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        addr_out_d = addr_out_q;
        len_d      = len_q;
        iss_cnt_d  = iss_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        rd_pend_d  = ren;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (LENGTH != '0) begin
                        state_d   = READ;
                        rd_addr_d = BASE_ADDR;
                        len_d     = LENGTH;
                        iss_cnt_d = '0;
                        pop_cnt_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (ren) begin
                    addr_out_d = rd_addr_q;
                    rd_addr_d  = rd_addr_q + 1'b1;
                    iss_cnt_d  = iss_cnt_q + 1'b1;
                    if (iss_cnt_q + 1'b1 == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && M_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop && state_q != IDLE) pop_cnt_d = pop_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            rd_addr_q  <= '0;
            addr_out_q <= '0;
            len_q      <= '0;
            iss_cnt_q  <= '0;
            pop_cnt_q  <= '0;
            rd_pend_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            addr_out_q <= addr_out_d;
            len_q      <= len_d;
            iss_cnt_q  <= iss_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            rd_pend_q  <= rd_pend_d;
            done_q     <= done_d;
        end
    end

    bram36k_skid_fifo u_fifo (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .push      (rd_pend_q),
        .push_data ({RPARITY, RDATA}),
        .pop       (pop),
        .count     (fifo_cnt),
        .out_valid (M_VALID),
        .out_data  (fifo_dout)
    );

    // The address bus shows the word being read, otherwise the last one read.
    assign word_addr = ren ? rd_addr_q : addr_out_q;
    assign ADDR      = 15'(word_addr) << ADDR_LSB;
    assign REN       = ren;
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign {M_PARITY, M_DATA} = fifo_dout;
    assign M_LAST    = M_VALID && (pop_cnt_q == len_q - 1'b1);

`ifdef BRAM36K_READER_PARITY_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (state_q == IDLE && START)
            perr_d = 1'b0;
        else if (rd_pend_q && (bram36k_byte_par(RDATA) != RPARITY))
            perr_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) perr_q <= 1'b0;
        else          perr_q <= perr_d;
    end

    assign PARITY_ERR = perr_q;
`else
    assign PARITY_ERR = 1'b0;
`endif
endmodule

// File: tb/tb_bram36k_reader.sv
// Scoreboard bench for bram36k_reader with a behavioural 1-cycle-latency RAM port model.
module tb_bram36k_reader;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        START = 1'b0;
    logic [9:0]  BASE_ADDR = '0;
    logic [10:0] LENGTH = '0;
    logic        M_READY = 1'b1;
    logic        BUSY, DONE, REN, M_VALID, M_LAST, PARITY_ERR;
    logic [14:0] ADDR;
    logic [31:0] RDATA, M_DATA;
    logic [3:0]  RPARITY, M_PARITY;

    int n_err = 0, n_chk = 0;
    int cyc = 0, start_cyc = 0;
    int issued = 0, accepted = 0, acc_tot = 0;
    int ren_cnt = 0, mv_cnt = 0, done_cnt = 0;
    int bad_addr = -1;
    logic       tog_en = 1'b0;
    logic [1:0] tog_idx = 2'd0;
    logic [3:0] pat = 4'b1001;

    logic [36:0] exp_q[$];
    logic [9:0]  addr_q[$];

    bram36k_reader dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH),
        .BUSY(BUSY), .DONE(DONE), .REN(REN), .ADDR(ADDR), .RDATA(RDATA), .RPARITY(RPARITY),
        .M_DATA(M_DATA), .M_PARITY(M_PARITY), .M_VALID(M_VALID), .M_READY(M_READY),
        .M_LAST(M_LAST), .PARITY_ERR(PARITY_ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [35:0] ram_word(input logic [9:0] a);
        logic [31:0] d;
        logic [3:0]  p;
        d = 32'(a) * 32'h0101_0101;
        for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
        return {p, d};
    endfunction

    // RAM port: registered read, optional parity-bit-2 corruption at one address.
    always @(posedge CLK) begin
        if (REN) begin
            logic [35:0] w;
            w = ram_word(ADDR[14:5]);
            if (int'(ADDR[14:5]) == bad_addr) w[34] = ~w[34];
            {RPARITY, RDATA} <= w;
        end
    end

    always @(posedge CLK) begin
        #1;
        M_READY = tog_en ? pat[tog_idx] : 1'b1;
        if (tog_en) tog_idx = tog_idx + 2'd1;
    end

    // Monitor: inputs change 1ns after posedge, so negedge sees what the next edge will sample.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            issued   = 0;
            accepted = 0;
        end else begin
            if (REN) begin
                logic [9:0] ea;
                chk("credit", 64'((issued - accepted - ((M_VALID && M_READY) ? 1 : 0)) < 2), 64'(1));
                if (addr_q.size() == 0) chk("addr_extra", 64'(1), 64'(0));
                else begin
                    ea = addr_q.pop_front();
                    chk("addr", 64'(ADDR), 64'({ea, 5'b0}));
                end
                issued++;
                ren_cnt++;
            end
            if (M_VALID) mv_cnt++;
            if (M_VALID && M_READY) begin
                logic [36:0] eb;
                if (exp_q.size() == 0) chk("beat_extra", 64'(1), 64'(0));
                else begin
                    eb = exp_q.pop_front();
                    chk("beat", 64'({M_LAST, M_PARITY, M_DATA}), 64'(eb));
                end
                accepted++;
                acc_tot++;
            end
            if (DONE) begin
                done_cnt++;
                chk("busy_at_done", 64'(BUSY), 64'(0));
            end
        end
    end

    task automatic start_xfer(input logic [9:0] base, input logic [10:0] len);
        @(posedge CLK); #1;
        START = 1'b1;
        BASE_ADDR = base;
        LENGTH = len;
        for (int i = 0; i < int'(len); i++) begin
            logic [9:0]  a;
            logic [35:0] w;
            a = base + 10'(i);
            w = ram_word(a);
            if (int'(a) == bad_addr) w[34] = ~w[34];
            addr_q.push_back(a);
            exp_q.push_back({(i == int'(len) - 1), w});
        end
        @(posedge CLK); #1;
        start_cyc = cyc;
        START = 1'b0;
    endtask

    // lat < 0 skips the latency comparison (used when backpressure makes it pattern dependent).
    task automatic wait_done(input int lat, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DONE && n < 300);
        if (!DONE) chk({tag, "_timeout"}, 64'(0), 64'(1));
        else if (lat >= 0) chk({tag, "_lat"}, 64'(cyc - start_cyc), 64'(lat));
        @(negedge CLK);
        chk({tag, "_pulse"}, 64'(DONE), 64'(0));
        chk({tag, "_left"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, m0, a0, n;
        logic perr_exp;
`ifdef BRAM36K_READER_PARITY_CHECK_EN
        perr_exp = 1'b1;
`else
        perr_exp = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_done", 64'(DONE), 64'(0));
        chk("rst_ren", 64'(REN), 64'(0));
        chk("rst_valid", 64'(M_VALID), 64'(0));
        chk("rst_last", 64'(M_LAST), 64'(0));
        chk("rst_perr", 64'(PARITY_ERR), 64'(0));
        chk("rst_addr", 64'(ADDR), 64'(0));
        chk("rst_data", 64'({M_PARITY, M_DATA}), 64'(0));
        @(posedge CLK); #1 RESET_N = 1'b1;

        // Basic transfer, with a START pulse during BUSY that must be ignored.
        start_xfer(10'h010, 11'd4);
        START = 1'b1; BASE_ADDR = 10'h200; LENGTH = 11'd3;
        @(posedge CLK); #1 START = 1'b0;
        chk("t1_busy", 64'(BUSY), 64'(1));
        wait_done(6, "t1");

        // Address wrap 0x3FF -> 0x000.
        start_xfer(10'h3FE, 11'd4);
        wait_done(6, "t2");

        // Backpressure with M_READY pattern 1,0,0,1.
        tog_en = 1'b1;
        start_xfer(10'h123, 11'd8);
        wait_done(-1, "t3");
        tog_en = 1'b0;

        // Zero length.
        r0 = ren_cnt; m0 = mv_cnt; d0 = done_cnt;
        start_xfer(10'h055, 11'd0);
        wait_done(0, "t4");
        chk("t4_no_ren", 64'(ren_cnt - r0), 64'(0));
        chk("t4_no_valid", 64'(mv_cnt - m0), 64'(0));
        chk("t4_one_done", 64'(done_cnt - d0), 64'(1));

        // Parity error on the third word, then cleared by the next START.
        bad_addr = 32'h102;
        start_xfer(10'h100, 11'd6);
        repeat (4) @(negedge CLK);
        chk("t5_perr_pre", 64'(PARITY_ERR), 64'(0));
        @(negedge CLK);
        chk("t5_perr_set", 64'(PARITY_ERR), 64'(perr_exp));
        wait_done(8, "t5");
        chk("t5_perr_hold", 64'(PARITY_ERR), 64'(perr_exp));
        bad_addr = -1;
        start_xfer(10'h000, 11'd1);
        @(negedge CLK);
        chk("t5_perr_clr", 64'(PARITY_ERR), 64'(0));
        wait_done(3, "t5b");

        // Reset in the middle of a transfer, then a clean restart.
        d0 = done_cnt; a0 = acc_tot;
        start_xfer(10'h2A0, 11'd10);
        n = 0;
        while (acc_tot < a0 + 2 && n < 50) begin
            @(posedge CLK); #2;
            n++;
        end
        chk("t6_reach_beat2", 64'(acc_tot >= a0 + 2), 64'(1));
        RESET_N = 1'b0;
        exp_q.delete();
        addr_q.delete();
        #1;
        chk("t6_rst_busy", 64'(BUSY), 64'(0));
        chk("t6_rst_valid", 64'(M_VALID), 64'(0));
        chk("t6_rst_ren", 64'(REN), 64'(0));
        repeat (2) @(posedge CLK);
        #1 RESET_N = 1'b1;
        start_xfer(10'h300, 11'd2);
        wait_done(4, "t6");
        chk("t6_single_done", 64'(done_cnt - d0), 64'(1));

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/bram36k_reader.md
# bram36k_reader

Sequential readback engine for one port of a 36-bit-wide TDP_RAM36K (1024 × 32 data + 4 parity). On a start command it walks a contiguous, wrap-around address range, issues single-cycle reads, and streams each 36-bit word out over a valid/ready interface with full backpressure. A 2-entry buffer absorbs the RAM's 1-cycle read latency. It sits between the BRAM primitive's read port and fabric consumers: scrub, debug dump and DMA readout.

## Interface
- Parameters:
- `ADDR_LSB`, 5: number of zero LSBs below the word address on `ADDR`. 36-bit mode uses `ADDR[14:5]`.
- Ports:
- `CLK` in 1: single clock; the RAM port clock is the same net.
- `RESET_N` in 1: asynchronous, active-low reset.
- `START` in 1: begin a transfer; sampled only in IDLE.
- `BASE_ADDR` in 10: first word address.
- `LENGTH` in 11: word count, 0..1024.
- `BUSY` out 1: transfer in progress.
- `DONE` out 1: one-cycle pulse at the end of a transfer.
- `REN` out 1: RAM read enable.
- `ADDR` out 15: RAM address, `{word_addr, ADDR_LSB'b0}`.
- `RDATA` in 32: RAM read data, valid 1 cycle after `REN`.
- `RPARITY` in 4: RAM read parity, same timing as `RDATA`.
- `M_DATA` out 32, `M_PARITY` out 4: stream payload.
- `M_VALID` out 1, `M_READY` in 1: stream handshake.
- `M_LAST` out 1: marks the final word of a transfer.
- `PARITY_ERR` out 1: sticky parity error (see Configuration).

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE:
  - `START`=1 with `LENGTH`≠0: latch the base address and length, go to READ, `BUSY`=1.
  - `START`=1 with `LENGTH`=0: pulse `DONE` next cycle, stay IDLE, never assert `REN`.
- READ:
  - Assert `REN` when (reads in flight + buffer occupancy) < 2 and issued < `LENGTH`.
  - Each issue increments the word address modulo 1024 (1023 → 0).
  - Go to DRAIN after the last read is issued.
- DRAIN: wait until the last word is accepted (`M_VALID`&`M_READY`&`M_LAST`), then pulse `DONE` and return to IDLE.
- Read data is captured into the 2-entry FIFO in the cycle after `REN`. Credit gating guarantees no overflow.
- `M_LAST` = 1 on the beat whose word count equals `LENGTH`.
- `START` while `BUSY` is ignored, with no effect on the current transfer.
- Stream rule: once `M_VALID` rises, payload is held stable until accepted.
- `ADDR` holds its last value when `REN`=0.
- Reset values: `BUSY`, `DONE`, `REN`, `M_VALID`, `M_LAST`, `PARITY_ERR` = 0; `ADDR`, `M_DATA`, `M_PARITY` = 0.

## Timing
- `START` sampled at edge N → first `REN` at cycle N+1 → `M_VALID` at N+2 at the earliest.
- With `M_READY` held high: 1 word/cycle sustained. A LENGTH=L transfer has its last beat at N+L+1 and `DONE` at N+L+2.
- `BUSY` deasserts in the same cycle `DONE` pulses.
- `M_READY` low: at most 2 words are buffered and `REN` stalls within 1 cycle. No word is lost or duplicated.
- Reset mid-transfer: asynchronous clear to IDLE. Buffered and in-flight words are discarded, and no `DONE` is produced.

## Configuration
- `BRAM36K_READER_PARITY_CHECK_EN` defined:
  - Each captured word is checked with even parity per byte: `RPARITY[i]` must equal `^RDATA[8i+7:8i]`.
  - Any mismatch sets `PARITY_ERR`. It stays set until the next accepted `START` (cleared in that cycle) or reset.
  - Data is streamed unchanged either way.
- Macro undefined: no checker logic; `PARITY_ERR` is tied to 0.

## Structure
- Package `bram36k_pkg`:
  - `BRAM36K_DEPTH`=1024, `BRAM36K_AW`=10, `BRAM36K_DW`=32, `BRAM36K_PW`=4.
  - State enum `bram36k_rd_state_t` {IDLE, READ, DRAIN}.
- Sub-module `bram36k_skid_fifo`: a 2-entry, 36-bit FIFO with push/pop/count, owning `M_VALID` and the payload registers.
- The top level holds the FSM, address/length counters, credit logic and parity checker.

## Test plan
1. `BASE_ADDR`=0x010, `LENGTH`=4, RAM model word = addr×0x01010101 with correct parity, `M_READY`=1 → beats 0x10101010..0x13131313; `M_LAST` on the 4th; `DONE` at START+6.
2. `BASE_ADDR`=0x3FE, `LENGTH`=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001, with `ADDR`=0x7FC0, 0x7FE0, 0x0000, 0x0020.
3. `LENGTH`=8 with `M_READY` toggling 1-0-0-1 → exactly 8 ordered, unduplicated words; `REN` never issues with 2 words buffered/in flight.
4. `LENGTH`=0 → `DONE` pulse 1 cycle after START, `REN` never asserted, no `M_VALID`.
5. Macro defined, word 3 of 6 returned with `RPARITY[2]` flipped → `PARITY_ERR` rises the cycle after capture and stays set; the next START clears it. Macro undefined → stays 0.
6. `RESET_N` low during beat 2 of `LENGTH`=10, then START with `LENGTH`=2 → clean restart, 2 words, no stale data, single `DONE`.
